// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back entry layout used by the
// write-back queue and its storage FIFO.
package rf_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int ERR_W  = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO   = 4'd0;
  localparam logic [ADDR_W-1:0] REG_ISZERO = 4'd3;
  localparam logic [ADDR_W-1:0] REG_ACC    = 4'd15;

  localparam int NUM_REGS = int'(REG_ACC) + 1;

  // Tag fields sit in the MSBs so the FIFO can expose them for scoreboarding.
  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic              wr_en;
    logic              z_en;
  } wb_tag_t;

  typedef struct packed {
    wb_tag_t           tag;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] z_data;
  } wb_entry_t;

  localparam int TAG_W   = $bits(wb_tag_t);
  localparam int ENTRY_W = $bits(wb_entry_t);

  // R0 is hard-wired and R3 is owned by the iszero path.
  function automatic logic is_legal_wa(input logic [ADDR_W-1:0] wa);
    return (wa != REG_ZERO) && (wa != REG_ISZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrapping pointers and a separate occupancy counter;
// also exposes the tag bits and validity of every slot for scoreboarding.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][TAG_W-1:0] slot_tags,
  output logic [DEPTH-1:0]            slot_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Caller guarantees push only when not full and pop only when not empty;
  // flush overrides both.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too so a reset leaves no stale entry behind;
      // affordable because DEPTH is at most 8.
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    offset     = '0;
    slot_valid = '0;
    slot_tags  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr;
      slot_valid[i] = ({1'b0, offset} < count);
      slot_tags[i]  = mem[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue between ALU/decoder and the register file: buffers entries,
// suppresses illegal writes, and publishes a pending-write scoreboard.
module wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_wa,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_wr_en,
  input  logic                in_z_en,
  input  logic [DATA_W-1:0]   in_z_data,
  input  logic                stall,
  input  logic                flush,
  output logic [ADDR_W-1:0]   wa,
  output logic [DATA_W-1:0]   write_data,
  output logic                reg_write,
  output logic [DATA_W-1:0]   iszero_data,
  output logic                iszero_write,
  output logic [NUM_REGS-1:0] pending,
  output logic [ERR_W-1:0]    err_cnt
);

  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic                        illegal;
  wb_entry_t                   in_entry;
  wb_entry_t                   head;
  logic [DEPTH-1:0][TAG_W-1:0] slot_tags;
  logic [DEPTH-1:0]            slot_valid;

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && !stall && !flush;
  assign illegal  = in_wr_en && !is_legal_wa(in_wa);

  // The stored wr_en already has the illegal write stripped out.
  assign in_entry = '{tag:    '{wa: in_wa, wr_en: in_wr_en && !illegal, z_en: in_z_en},
                      data:   in_data,
                      z_data: in_z_data};

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .wdata      (in_entry),
    .rdata      (head),
    .full       (full),
    .empty      (empty),
    .slot_tags  (slot_tags),
    .slot_valid (slot_valid)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wa           <= '0;
      write_data   <= '0;
      iszero_data  <= '0;
      reg_write    <= 1'b0;
      iszero_write <= 1'b0;
      err_cnt      <= '0;
    end else begin
      reg_write    <= pop && head.tag.wr_en;
      iszero_write <= pop && head.tag.z_en;
      if (pop) begin
        wa          <= head.tag.wa;
        write_data  <= head.data;
        iszero_data <= head.z_data;
      end
      if (push && illegal && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // A presented entry still counts as pending during its strobe cycle.
  always_comb begin
    wb_tag_t t;
    t       = '0;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      t = wb_tag_t'(slot_tags[i]);
      if (slot_valid[i] && t.wr_en) pending[t.wa]      = 1'b1;
      if (slot_valid[i] && t.z_en)  pending[REG_ISZERO] = 1'b1;
    end
    if (reg_write)    pending[wa]         = 1'b1;
    if (iszero_write) pending[REG_ISZERO] = 1'b1;
  end

endmodule
